// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the 3-stage pipeline hazard controller:
// opcode set, forwarding select encodings, FSM states and operand-usage decode.
package hazard_ctrl_pkg;

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_ARI_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_ARI_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_NOOP      = 7'b0000000;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_ALU     = 2'b01;
    localparam logic [1:0] FWD_LOAD    = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_LOAD_WAIT = 2'd1,
        ST_REDIRECT  = 2'd2
    } hz_state_e;

    function automatic logic writes_rd(input logic [6:0] op);
        return !(op inside {OP_BRANCH, OP_STORE, OP_NOOP});
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op inside {OP_LUI, OP_AUIPC, OP_JAL, OP_NOOP});
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return op inside {OP_ARI_RTYPE, OP_STORE, OP_BRANCH};
    endfunction

    function automatic logic is_load(input logic [6:0] op);
        return op == OP_LOAD;
    endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_cmp.sv
// One operand's forwarding comparator: matches an S2 source field against the
// S3 destination and picks ALU-result or load-data bypass.
module hazard_fwd_cmp
    import hazard_ctrl_pkg::*;
(
    input  logic       s2_valid_i,
    input  logic       s3_valid_i,
    input  logic       operand_used_i,
    input  logic [4:0] rs_i,
    input  logic [4:0] rd_i,
    input  logic       s3_writes_rd_i,
    input  logic       s3_is_load_i,
    output logic [1:0] sel_o
);

    logic hit;

    // x0 is hardwired zero, so a write to it must never be bypassed.
    assign hit = s2_valid_i & s3_valid_i & s3_writes_rd_i & (rd_i != 5'd0)
               & operand_used_i & (rs_i == rd_i);

    assign sel_o = !hit        ? FWD_REGFILE :
                   s3_is_load_i ? FWD_LOAD    : FWD_ALU;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 3-stage core: operand forwarding, load-use freeze
// while S3 waits on dmem, and S2 flush bubbles after a redirect resolved in S2.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REDIRECT_BUBBLES = 2,
    parameter int LOAD_TIMEOUT     = 64,
    parameter int CNT_W            = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] s2_inst,
    input  logic [31:0] s3_inst,
    input  logic        s2_redirect,
    input  logic        dmem_rvalid,
    output logic        stall,
    output logic        flush_s2,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        s2_valid,
    output logic        s3_valid,
    output logic        load_timeout
);

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] LT_CNT      = CNT_W'(LOAD_TIMEOUT);
    localparam logic [CNT_W-1:0] LT_M1       = CNT_W'(LOAD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RB_LAST     = CNT_W'(REDIRECT_BUBBLES - 1);
    localparam bit               LT_IS_ONE   = (LOAD_TIMEOUT == 1);
    localparam bit               MULTI_BUBBLE = (REDIRECT_BUBBLES > 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s2_valid_q, s3_valid_q;

    logic [6:0] s2_op, s3_op;
    logic       s3_load, s3_writes;
    logic       load_pend, redirect_ok;
    logic       unused_inst_bits;

    assign s2_op     = s2_inst[6:0];
    assign s3_op     = s3_inst[6:0];
    assign s3_load   = is_load(s3_op);
    assign s3_writes = writes_rd(s3_op);

    assign unused_inst_bits = ^{s2_inst[31:25], s2_inst[14:7], s3_inst[31:12]};

    assign load_pend   = s3_valid_q & s3_load & ~dmem_rvalid;
    // A frozen S2 keeps s2_redirect high, so it is picked up on the release cycle.
    assign redirect_ok = s2_redirect & s2_valid_q & ~load_pend;

    hazard_fwd_cmp u_fwd_a (
        .s2_valid_i     (s2_valid_q),
        .s3_valid_i     (s3_valid_q),
        .operand_used_i (uses_rs1(s2_op)),
        .rs_i           (s2_inst[19:15]),
        .rd_i           (s3_inst[11:7]),
        .s3_writes_rd_i (s3_writes),
        .s3_is_load_i   (s3_load),
        .sel_o          (fwd_a_sel)
    );

    hazard_fwd_cmp u_fwd_b (
        .s2_valid_i     (s2_valid_q),
        .s3_valid_i     (s3_valid_q),
        .operand_used_i (uses_rs2(s2_op)),
        .rs_i           (s2_inst[24:20]),
        .rd_i           (s3_inst[11:7]),
        .s3_writes_rd_i (s3_writes),
        .s3_is_load_i   (s3_load),
        .sel_o          (fwd_b_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_RUN, ST_LOAD_WAIT: begin
                if (load_pend) begin
                    if (state_q == ST_RUN) begin
                        state_d = ST_LOAD_WAIT;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q < LT_CNT) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (redirect_ok && MULTI_BUBBLE) begin
                    state_d = ST_REDIRECT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_REDIRECT: begin
                if (cnt_q == RB_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        stall        = load_pend;
        flush_s2     = 1'b0;
        load_timeout = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                flush_s2     = redirect_ok;
                load_timeout = load_pend & LT_IS_ONE;
            end
            ST_LOAD_WAIT: begin
                flush_s2     = redirect_ok;
                // Pulse on the stalled cycle whose increment brings cnt to the limit.
                load_timeout = load_pend & (cnt_q == LT_M1);
            end
            ST_REDIRECT: begin
                flush_s2 = 1'b1;
            end
            default: begin
                flush_s2 = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
        end else if (!stall) begin
            s3_valid_q <= s2_valid_q;
            s2_valid_q <= !flush_s2;
        end
    end

    assign s2_valid = s2_valid_q;
    assign s3_valid = s3_valid_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-level reference model checked every
// negedge, plus hand-computed expectations at key points of each scenario.
module tb_hazard_ctrl;

    localparam int RB = 2;
    localparam int LT = 8;

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6f, BRANCH = 7'h63;
    localparam logic [6:0] LOAD = 7'h03, STORE = 7'h23, ITYPE = 7'h13, RTYPE = 7'h33, NOOP = 7'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s2_inst = '0;
    logic [31:0] s3_inst = '0;
    logic        s2_redirect = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic        stall, flush_s2, s2_valid, s3_valid, load_timeout;
    logic [1:0]  fwd_a_sel, fwd_b_sel;

    int n_checks = 0;
    int n_fail   = 0;

    hazard_ctrl #(.REDIRECT_BUBBLES(RB), .LOAD_TIMEOUT(LT), .CNT_W(7)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s2_inst      (s2_inst),
        .s3_inst      (s3_inst),
        .s2_redirect  (s2_redirect),
        .dmem_rvalid  (dmem_rvalid),
        .stall        (stall),
        .flush_s2     (flush_s2),
        .fwd_a_sel    (fwd_a_sel),
        .fwd_b_sel    (fwd_b_sel),
        .s2_valid     (s2_valid),
        .s3_valid     (s3_valid),
        .load_timeout (load_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    // Reference model: pipeline occupancy, pending forced bubbles, stalled-cycle run length.
    logic m_s2v = 1'b0, m_s3v = 1'b0;
    int   bubbles_left = 0;
    int   stall_run = 0;
    logic e_stall = 1'b0, e_acc = 1'b0, e_flush = 1'b0;

    function automatic logic [1:0] model_fwd(input logic [31:0] s2, input logic [31:0] s3,
                                             input bit second, input logic v2, input logic v3);
        logic [6:0] op2, op3;
        logic [4:0] rd, rs;
        bit         wr, used;
        op2  = s2[6:0];
        op3  = s3[6:0];
        rd   = s3[11:7];
        rs   = second ? s2[24:20] : s2[19:15];
        wr   = !(op3 == BRANCH || op3 == STORE || op3 == NOOP);
        if (second) used = (op2 == RTYPE || op2 == STORE || op2 == BRANCH);
        else        used = !(op2 == LUI || op2 == AUIPC || op2 == JAL || op2 == NOOP);
        if (!(v2 && v3 && wr && rd != 5'd0 && used && rs == rd)) return 2'b00;
        return (op3 == LOAD) ? 2'b10 : 2'b01;
    endfunction

    always @(negedge clk) begin
        logic e_to;
        e_stall = m_s3v && (s3_inst[6:0] == LOAD) && !dmem_rvalid;
        e_acc   = !e_stall && s2_redirect && m_s2v && bubbles_left == 0;
        e_flush = (bubbles_left > 0) || e_acc;
        e_to    = e_stall && (stall_run + 1 == LT);
        chk("m_stall", stall, e_stall);
        chk("m_flush", flush_s2, e_flush);
        chk("m_timeout", load_timeout, e_to);
        chk("m_s2_valid", s2_valid, m_s2v);
        chk("m_s3_valid", s3_valid, m_s3v);
        chk("m_fwd_a", fwd_a_sel, model_fwd(s2_inst, s3_inst, 1'b0, m_s2v, m_s3v));
        chk("m_fwd_b", fwd_b_sel, model_fwd(s2_inst, s3_inst, 1'b1, m_s2v, m_s3v));
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s2v = 1'b0;
            m_s3v = 1'b0;
            bubbles_left = 0;
            stall_run = 0;
            e_stall = 1'b0;
            e_acc = 1'b0;
            e_flush = 1'b0;
        end else begin
            if (!e_stall) begin
                m_s3v = m_s2v;
                m_s2v = !e_flush;
            end
            stall_run = e_stall ? stall_run + 1 : 0;
            if (bubbles_left > 0) bubbles_left--;
            else if (e_acc) bubbles_left = RB - 1;
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_flush", flush_s2, 0);
        chk("rst_s2_valid", s2_valid, 0);
        chk("rst_s3_valid", s3_valid, 0);
        chk("rst_timeout", load_timeout, 0);

        // add x5,x1,x2 in S3; sub x6,x1,x5 in S2; valids fill after reset release.
        s3_inst = mk(RTYPE, 5, 1, 2);
        s2_inst = mk(RTYPE, 6, 1, 5);
        rst_n = 1'b1;
        #1;
        chk("inv_fwd_b", fwd_b_sel, 2'b00);
        next(); #1;
        chk("fill_s2_valid", s2_valid, 1);
        chk("s3inv_fwd_b", fwd_b_sel, 2'b00);
        next(); #1;
        chk("t1_s3_valid", s3_valid, 1);
        chk("t1_fwd_a", fwd_a_sel, 2'b00);
        chk("t1_fwd_b", fwd_b_sel, 2'b01);
        chk("t1_stall", stall, 0);
        next();

        // lw x7 stalls 3 cycles; add x8,x7,x7 takes load data on release.
        s3_inst = mk(LOAD, 7, 2, 0);
        s2_inst = mk(RTYPE, 8, 7, 7);
        dmem_rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall", stall, 1);
            chk("t2_fwd_a_wait", fwd_a_sel, 2'b10);
            next();
        end
        dmem_rvalid = 1'b1;
        #1;
        chk("t2_release_stall", stall, 0);
        chk("t2_fwd_a", fwd_a_sel, 2'b10);
        chk("t2_fwd_b", fwd_b_sel, 2'b10);
        next();
        dmem_rvalid = 1'b0;
        s3_inst = mk(RTYPE, 8, 7, 7);
        s2_inst = mk(ITYPE, 12, 3, 0);
        #1;
        chk("t2_after_fwd_a", fwd_a_sel, 2'b00);
        next();

        // One-cycle redirect in RUN: two flush cycles, then valid holes.
        s3_inst = mk(RTYPE, 9, 1, 1);
        s2_inst = mk(BRANCH, 0, 9, 4);
        s2_redirect = 1'b1;
        #1;
        chk("t3_flush0", flush_s2, 1);
        chk("t3_branch_fwd_a", fwd_a_sel, 2'b01);
        next();
        s2_redirect = 1'b0;
        s3_inst = mk(BRANCH, 0, 9, 4);
        s2_inst = '0;
        #1;
        chk("t3_flush1", flush_s2, 1);
        chk("t3_s2_valid1", s2_valid, 0);
        chk("t3_s3_valid1", s3_valid, 1);
        next();
        s3_inst = '0;
        s2_inst = mk(ITYPE, 13, 1, 0);
        #1;
        chk("t3_flush2", flush_s2, 0);
        chk("t3_s2_valid2", s2_valid, 0);
        chk("t3_s3_valid2", s3_valid, 0);
        next(); #1;
        chk("t3_s2_valid3", s2_valid, 1);
        chk("t3_s3_valid3", s3_valid, 0);
        next();
        s3_inst = mk(ITYPE, 13, 1, 0);
        s2_inst = mk(RTYPE, 14, 13, 2);
        #1;
        chk("t3_s3_valid4", s3_valid, 1);
        chk("t3_fwd_a", fwd_a_sel, 2'b01);
        next();

        // Redirect held through a 4-cycle load stall; accepted on release.
        s3_inst = mk(LOAD, 10, 1, 0);
        s2_inst = mk(JAL, 1, 0, 0);
        s2_redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t4_stall", stall, 1);
            chk("t4_no_flush", flush_s2, 0);
            next();
        end
        dmem_rvalid = 1'b1;
        #1;
        chk("t4_release_stall", stall, 0);
        chk("t4_release_flush", flush_s2, 1);
        next();
        dmem_rvalid = 1'b0;
        s2_redirect = 1'b0;
        s3_inst = mk(JAL, 1, 0, 0);
        s2_inst = '0;
        #1;
        chk("t4_flush1", flush_s2, 1);
        chk("t4_s2_valid", s2_valid, 0);
        next();
        s3_inst = '0;
        s2_inst = mk(ITYPE, 2, 1, 0);
        #1;
        chk("t4_flush2", flush_s2, 0);
        next();
        next();

        // x0 destination and non-writing S3 never forward.
        s3_inst = mk(RTYPE, 0, 1, 2);
        s2_inst = mk(RTYPE, 6, 0, 0);
        #1;
        chk("t6_valids", {s2_valid, s3_valid}, 2'b11);
        chk("t6_x0_fwd_a", fwd_a_sel, 2'b00);
        chk("t6_x0_fwd_b", fwd_b_sel, 2'b00);
        next();
        s3_inst = mk(STORE, 6, 1, 2);
        s2_inst = mk(RTYPE, 7, 6, 6);
        #1;
        chk("t6_store_fwd_a", fwd_a_sel, 2'b00);
        next();

        // Load never answered: one timeout pulse on stalled cycle LT, stall persists.
        s3_inst = mk(LOAD, 11, 1, 0);
        s2_inst = mk(RTYPE, 15, 11, 0);
        pulses = 0;
        for (int i = 1; i <= 12; i++) begin
            #1;
            chk("t5_stall", stall, 1);
            chk("t5_timeout", load_timeout, (i == LT) ? 1 : 0);
            if (load_timeout) pulses++;
            next();
        end
        chk("t5_pulse_count", pulses, 1);

        // Reset in the middle of the load wait.
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall", stall, 0);
        chk("rstmid_s2_valid", s2_valid, 0);
        chk("rstmid_s3_valid", s3_valid, 0);
        chk("rstmid_flush", flush_s2, 0);
        chk("rstmid_timeout", load_timeout, 0);
        s3_inst = '0;
        next();
        next();
        rst_n = 1'b1;
        #1;
        chk("rel_stall", stall, 0);
        next(); #1;
        chk("rel_s2_valid", s2_valid, 1);
        chk("rel_flush", flush_s2, 0);
        next(); #1;
        chk("rel_s3_valid", s3_valid, 1);
        next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
